gvp_program_sequencer: RTL

GVP_PROGRAM_SEQUENCER -- requirements
Module: gvp_program_sequencer

---
 rtl/gvp_program_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/gvp_program_sequencer.sv
// Loads 16-word vectors from an AXI-Stream into gvp_vp_set and pulses gvp_setvec, then runs the program with gvp_reset windows.
// Outputs are registered state decodes (one cycle after the causing edge); tready drops outside IDLE/LOAD to stall the stream.
module gvp_program_sequencer #(
   parameter int SET_CYCLES  = 4,
   parameter int HOLD_CYCLES = 8
) (
   input  logic         a_clk,
   input  logic         a_resetn,
   input  logic [31:0]  S_AXIS_tdata,
   input  logic         S_AXIS_tvalid,
   output logic         S_AXIS_tready,
   input  logic         S_AXIS_tlast,
   input  logic         start,
   input  logic         abort,
   input  logic [15:0]  run_count,
   output logic         gvp_reset,
   output logic         gvp_setvec,
   output logic [511:0] gvp_vp_set,
   input  logic         gvp_finished,
   output logic [2:0]   state,
   output logic [7:0]   vectors_loaded,
   output logic [15:0]  runs_done,
   output logic         program_valid,
   output logic         load_error
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SET  = 3'd2,
      GAP  = 3'd3,
      ARM  = 3'd4,
      RUN  = 3'd5,
      HOLD = 3'd6
   } state_t;

   localparam logic [15:0] SET_LAST  = 16'(SET_CYCLES - 1);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] ARM_LAST  = 16'd1;

   state_t        state_q, state_d;
   logic [3:0]    k_q, k_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [511:0]  vp_set_q, vp_set_d;
   logic [7:0]    vec_cnt_q, vec_cnt_d;
   logic [15:0]   runs_q, runs_d;
   logic [15:0]   target_q, target_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic          last_vec_q, last_vec_d;
   logic          rdy_en_q, rdy_en_d;
   logic          xfer;

   // rdy_en_q keeps tready low for the first cycle after reset release
   assign S_AXIS_tready  = rdy_en_q && (state_q == IDLE || state_q == LOAD);
   assign xfer           = S_AXIS_tvalid && S_AXIS_tready;
   assign gvp_reset      = !(state_q == ARM || state_q == RUN);
   assign gvp_setvec     = (state_q == SET);
   assign gvp_vp_set     = vp_set_q;
   assign state          = state_q;
   assign vectors_loaded = vec_cnt_q;
   assign runs_done      = runs_q;
   assign program_valid  = valid_q;
   assign load_error     = err_q;

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      cnt_d      = cnt_q;
      vp_set_d   = vp_set_q;
      vec_cnt_d  = vec_cnt_q;
      runs_d     = runs_q;
      target_d   = target_q;
      valid_d    = valid_q;
      err_d      = err_q;
      last_vec_d = last_vec_q;
      rdy_en_d   = 1'b1;

      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         k_d     = 4'd0;
         cnt_d   = 16'd0;
         if (state_q == LOAD || state_q == SET || state_q == GAP) begin
            valid_d = 1'b0;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (xfer) begin
                  if (valid_q || err_q) begin
                     vec_cnt_d = 8'd0;
                     valid_d   = 1'b0;
                     err_d     = 1'b0;
                  end
                  vp_set_d[{k_q, 5'd0} +: 32] = S_AXIS_tdata;
                  if (S_AXIS_tlast) begin
                     err_d   = 1'b1;
                     valid_d = 1'b0;
                     k_d     = 4'd0;
                  end else begin
                     state_d = LOAD;
                     k_d     = 4'd1;
                  end
               end else if (start && valid_q) begin
                  state_d  = ARM;
                  cnt_d    = 16'd0;
                  runs_d   = 16'd0;
                  target_d = (run_count == 16'd0) ? 16'd1 : run_count;
               end
            end
            LOAD: begin
               if (xfer) begin
                  vp_set_d[{k_q, 5'd0} +: 32] = S_AXIS_tdata;
                  if (k_q == 4'd15) begin
                     state_d    = SET;
                     cnt_d      = 16'd0;
                     k_d        = 4'd0;
                     last_vec_d = S_AXIS_tlast;
                  end else if (S_AXIS_tlast) begin
                     state_d = IDLE;
                     err_d   = 1'b1;
                     valid_d = 1'b0;
                     k_d     = 4'd0;
                  end else begin
                     k_d = k_q + 4'd1;
                  end
               end
            end
            SET: begin
               if (cnt_q == SET_LAST) begin
                  state_d = GAP;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            GAP: begin
               if (cnt_q == SET_LAST) begin
                  cnt_d = 16'd0;
                  if (vec_cnt_q != 8'hFF) begin
                     vec_cnt_d = vec_cnt_q + 8'd1;
                  end
                  if (last_vec_q) begin
                     state_d = IDLE;
                     valid_d = 1'b1;
                  end else begin
                     state_d = LOAD;
                     k_d     = 4'd0;
                  end
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            ARM: begin
               // gvp_finished is deliberately ignored here so a stuck flag cannot skip the run
               if (cnt_q == ARM_LAST) begin
                  state_d = RUN;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            RUN: begin
               if (gvp_finished) begin
                  state_d = HOLD;
                  cnt_d   = 16'd0;
                  if (runs_q != 16'hFFFF) begin
                     runs_d = runs_q + 16'd1;
                  end
               end
            end
            HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_d   = 16'd0;
                  state_d = (runs_q < target_q) ? ARM : IDLE;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 16'd0;
               k_d     = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge a_clk or negedge a_resetn) begin
      if (!a_resetn) begin
         state_q    <= IDLE;
         k_q        <= 4'd0;
         cnt_q      <= 16'd0;
         vp_set_q   <= '0;
         vec_cnt_q  <= 8'd0;
         runs_q     <= 16'd0;
         target_q   <= 16'd1;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         last_vec_q <= 1'b0;
         rdy_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         cnt_q      <= cnt_d;
         vp_set_q   <= vp_set_d;
         vec_cnt_q  <= vec_cnt_d;
         runs_q     <= runs_d;
         target_q   <= target_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         last_vec_q <= last_vec_d;
         rdy_en_q   <= rdy_en_d;
      end
   end

endmodule
